// File: rtl/data_ram_responder.sv
// Data-side SRAM responder for the RV32I execute stage: byte-enabled stores, right-aligned loads, stall control.
// Define DATA_RAM_SPLIT_EN to split misaligned accesses into two SRAM accesses; otherwise they raise misaligned_err.
module data_ram_responder #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ram_load_en,
    input  logic                  ram_store_en,
    input  logic [31:0]           ram_load_addr,
    input  logic [31:0]           ram_store_addr,
    input  logic [31:0]           ram_store_data,
    input  logic [1:0]            ram_load_width,
    input  logic [1:0]            ram_store_width,
    output logic [31:0]           ram_load_data,
    output logic                  stall_req,
    output logic                  misaligned_err,
    output logic                  sram_en,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [3:0]            sram_be,
    output logic [31:0]           sram_wdata,
    input  logic [31:0]           sram_rdata
);

`ifdef DATA_RAM_SPLIT_EN
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LD_DATA = 3'd1,
        LD_HI   = 3'd2,
        LD_JOIN = 3'd3,
        ST_HI   = 3'd4
    } state_e;
`else
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LD_DATA = 3'd1
    } state_e;
`endif

    state_e                  state_q, state_d;
    logic [1:0]              offset_q, offset_d;
    logic [31:0]             load_data_q, load_data_d;

    logic [1:0]              ld_off, st_off;
    logic [ADDR_WIDTH-1:0]   ld_word, st_word;
    logic                    ld_mis, st_mis;
    logic [7:0]              st_be8;
    logic [63:0]             st_wdata64;
    logic [31:0]             rd_shift;
    logic [31:0]             done_data;
    logic                    unused_bits;

    function automatic logic [3:0] width_mask(input logic [1:0] w);
        case (w)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // An access is misaligned only when its bytes would cross into the next word.
    function automatic logic misaligned(input logic [1:0] w, input logic [1:0] off);
        if (w == 2'b01)
            return off == 2'b11;
        return w[1] && (off != 2'b00);
    endfunction

    assign ld_off     = ram_load_addr[1:0];
    assign st_off     = ram_store_addr[1:0];
    assign ld_word    = ram_load_addr[ADDR_WIDTH+1:2];
    assign st_word    = ram_store_addr[ADDR_WIDTH+1:2];
    assign ld_mis     = misaligned(ram_load_width, ld_off);
    assign st_mis     = misaligned(ram_store_width, st_off);
    assign st_be8     = {4'b0000, width_mask(ram_store_width)} << st_off;
    assign st_wdata64 = {32'd0, ram_store_data} << {st_off, 3'b000};
    assign rd_shift   = sram_rdata >> {offset_q, 3'b000};

`ifdef DATA_RAM_SPLIT_EN
    logic [31:0] lo_q, lo_d;
    logic [31:0] join_lo;

    assign join_lo     = 32'({sram_rdata, lo_q} >> {offset_q, 3'b000});
    assign done_data   = (state_q == LD_JOIN) ? join_lo : rd_shift;
    assign unused_bits = ^{ram_load_addr[31:ADDR_WIDTH+2], ram_store_addr[31:ADDR_WIDTH+2]};
`else
    assign done_data   = rd_shift;
    assign unused_bits = ^{ram_load_addr[31:ADDR_WIDTH+2], ram_store_addr[31:ADDR_WIDTH+2],
                           st_be8[7:4], st_wdata64[63:32]};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            offset_q    <= 2'b00;
            load_data_q <= 32'd0;
`ifdef DATA_RAM_SPLIT_EN
            lo_q        <= 32'd0;
`endif
        end else begin
            state_q     <= state_d;
            offset_q    <= offset_d;
            load_data_q <= load_data_d;
`ifdef DATA_RAM_SPLIT_EN
            lo_q        <= lo_d;
`endif
        end
    end

    always_comb begin
        state_d        = state_q;
        offset_d       = offset_q;
        load_data_d    = load_data_q;
`ifdef DATA_RAM_SPLIT_EN
        lo_d           = lo_q;
`endif
        ram_load_data  = load_data_q;
        stall_req      = 1'b0;
        misaligned_err = 1'b0;
        sram_en        = 1'b0;
        sram_we        = 1'b0;
        sram_addr      = '0;
        sram_be        = 4'b0000;
        sram_wdata     = 32'd0;

        case (state_q)
            IDLE: begin
                if (ram_load_en) begin
                    if (ld_mis) begin
`ifdef DATA_RAM_SPLIT_EN
                        sram_en   = 1'b1;
                        sram_addr = ld_word;
                        stall_req = 1'b1;
                        offset_d  = ld_off;
                        state_d   = LD_HI;
`else
                        misaligned_err = 1'b1;
                        ram_load_data  = 32'd0;
                        load_data_d    = 32'd0;
`endif
                    end else begin
                        sram_en   = 1'b1;
                        sram_addr = ld_word;
                        stall_req = 1'b1;
                        offset_d  = ld_off;
                        state_d   = LD_DATA;
                    end
                end else if (ram_store_en) begin
                    if (st_mis) begin
`ifdef DATA_RAM_SPLIT_EN
                        sram_en    = 1'b1;
                        sram_we    = 1'b1;
                        sram_addr  = st_word;
                        sram_be    = st_be8[3:0];
                        sram_wdata = st_wdata64[31:0];
                        stall_req  = 1'b1;
                        state_d    = ST_HI;
`else
                        misaligned_err = 1'b1;
                        ram_load_data  = 32'd0;
                        load_data_d    = 32'd0;
`endif
                    end else begin
                        sram_en    = 1'b1;
                        sram_we    = 1'b1;
                        sram_addr  = st_word;
                        sram_be    = st_be8[3:0];
                        sram_wdata = st_wdata64[31:0];
                    end
                end
            end
`ifdef DATA_RAM_SPLIT_EN
            LD_DATA, LD_JOIN: begin
`else
            LD_DATA: begin
`endif
                ram_load_data = done_data;
                load_data_d   = done_data;
                state_d       = IDLE;
                // A store held alongside the load goes out here; only a single-word store fits this slot.
                if (ram_store_en) begin
                    if (!st_mis) begin
                        sram_en    = 1'b1;
                        sram_we    = 1'b1;
                        sram_addr  = st_word;
                        sram_be    = st_be8[3:0];
                        sram_wdata = st_wdata64[31:0];
                    end
`ifndef DATA_RAM_SPLIT_EN
                    else begin
                        misaligned_err = 1'b1;
                    end
`endif
                end
            end
`ifdef DATA_RAM_SPLIT_EN
            LD_HI: begin
                lo_d      = sram_rdata;
                sram_en   = 1'b1;
                sram_addr = ld_word + ADDR_WIDTH'(1);
                stall_req = 1'b1;
                state_d   = LD_JOIN;
            end
            ST_HI: begin
                sram_en    = 1'b1;
                sram_we    = 1'b1;
                sram_addr  = st_word + ADDR_WIDTH'(1);
                sram_be    = st_be8[7:4];
                sram_wdata = st_wdata64[63:32];
                state_d    = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase

        // Reset must silence the strobes immediately, not just at the next edge.
        if (rst) begin
            ram_load_data  = 32'd0;
            stall_req      = 1'b0;
            misaligned_err = 1'b0;
            sram_en        = 1'b0;
            sram_we        = 1'b0;
            sram_addr      = '0;
            sram_be        = 4'b0000;
            sram_wdata     = 32'd0;
        end
    end

endmodule

// File: tb/tb_data_ram_responder.sv
// Self-checking bench for data_ram_responder: SRAM behavioural model plus a byte-array reference memory.
module tb_data_ram_responder;
    localparam int AW = 12;
    localparam int NB = 4 * (1 << AW);
`ifdef DATA_RAM_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          ram_load_en, ram_store_en;
    logic [31:0]   ram_load_addr, ram_store_addr, ram_store_data;
    logic [1:0]    ram_load_width, ram_store_width;
    logic [31:0]   ram_load_data;
    logic          stall_req, misaligned_err;
    logic          sram_en, sram_we;
    logic [AW-1:0] sram_addr;
    logic [3:0]    sram_be;
    logic [31:0]   sram_wdata;
    logic [31:0]   sram_rdata;

    logic [31:0]   mem [0:(1<<AW)-1];
    logic [7:0]    ref_mem [0:NB-1];
    int            n_cmp = 0;
    int            n_fail = 0;

    logic [3:0]    s_be    [0:3];
    logic [AW-1:0] s_addr  [0:3];
    logic [31:0]   s_wdata [0:3];
    logic          s_we    [0:3];

    data_ram_responder #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .ram_load_en(ram_load_en), .ram_store_en(ram_store_en),
        .ram_load_addr(ram_load_addr), .ram_store_addr(ram_store_addr),
        .ram_store_data(ram_store_data),
        .ram_load_width(ram_load_width), .ram_store_width(ram_store_width),
        .ram_load_data(ram_load_data), .stall_req(stall_req),
        .misaligned_err(misaligned_err),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_be(sram_be), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we) begin
                for (int b = 0; b < 4; b++)
                    if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    function automatic int nbytes(input logic [1:0] w);
        return (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit spans(input logic [31:0] a, input logic [1:0] w);
        return (int'(a[1:0]) + nbytes(w)) > 4;
    endfunction

    function automatic logic [31:0] wmask(input logic [1:0] w);
        return (w == 2'b00) ? 32'h0000_00FF : (w == 2'b01) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a, input logic [1:0] w);
        logic [31:0] v;
        int base;
        v = 32'd0;
        base = int'({18'd0, a[AW+1:0]});
        for (int i = 0; i < nbytes(w); i++)
            v[8*i +: 8] = ref_mem[(base + i) % NB];
        return v;
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [1:0] w, input logic [31:0] d);
        int base;
        base = int'({18'd0, a[AW+1:0]});
        for (int i = 0; i < nbytes(w); i++)
            ref_mem[(base + i) % NB] = d[8*i +: 8];
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] r;
        logic [AW-1:0] wi;
        r = $urandom;
        if ($urandom_range(0, 1) == 0) wi = AW'($urandom_range(0, 63));
        else                           wi = AW'($urandom_range(4032, 4095));
        return {r[31:AW+2], wi, r[1:0]};
    endfunction

    // Drives one request and holds it until stall_req drops; stalls=99 marks an expired cycle budget.
    task automatic access(input logic le, input logic se,
                          input logic [31:0] la, input logic [1:0] lw,
                          input logic [31:0] sa, input logic [1:0] sw, input logic [31:0] sd,
                          output logic [31:0] ld, output int stalls, output logic err,
                          output int strobes);
        bit done;
        ram_load_en = le; ram_store_en = se;
        ram_load_addr = la; ram_load_width = lw;
        ram_store_addr = sa; ram_store_width = sw; ram_store_data = sd;
        stalls = 0; strobes = 0; err = 1'b0; ld = 32'd0; done = 1'b0;
        for (int c = 0; c < 6 && !done; c++) begin
            @(negedge clk);
            if (sram_en) begin
                if (strobes < 4) begin
                    s_be[strobes] = sram_be; s_addr[strobes] = sram_addr;
                    s_wdata[strobes] = sram_wdata; s_we[strobes] = sram_we;
                end
                strobes++;
            end
            if (misaligned_err) err = 1'b1;
            if (stall_req) stalls++;
            else begin ld = ram_load_data; done = 1'b1; end
            @(posedge clk); #1;
        end
        if (!done) stalls = 99;
        ram_load_en = 1'b0; ram_store_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ram_load_en = 1'b1; ram_load_addr = 32'h10; ram_load_width = 2'b10;
        ram_store_en = 1'b1; ram_store_addr = 32'h20; ram_store_width = 2'b10; ram_store_data = 32'h1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall_req); end
        n_cmp++; if (sram_en !== 1'b0) begin n_fail++; $display("FAIL reset_sram_en: got %b want 0", sram_en); end
        n_cmp++; if (sram_we !== 1'b0) begin n_fail++; $display("FAIL reset_sram_we: got %b want 0", sram_we); end
        n_cmp++; if (sram_be !== 4'b0) begin n_fail++; $display("FAIL reset_sram_be: got %b want 0000", sram_be); end
        n_cmp++; if (ram_load_data !== 32'd0) begin n_fail++; $display("FAIL reset_load_data: got %h want 0", ram_load_data); end
        n_cmp++; if (misaligned_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", misaligned_err); end
        ram_load_en = 1'b0; ram_store_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_preload();
        logic [31:0] ld, d;
        int st, sb;
        logic e;
        for (int i = 0; i < 128; i++) begin
            int wi;
            wi = (i < 64) ? i : 4032 + (i - 64);
            d = $urandom;
            access(1'b0, 1'b1, 32'd0, 2'b00, 32'(wi * 4), 2'b10, d, ld, st, e, sb);
            ref_write(32'(wi * 4), 2'b10, d);
            n_cmp++; if (st !== 0) begin n_fail++; $display("FAIL preload_stall: got %0d want 0", st); end
        end
    endtask

    task automatic test_plan_aligned();
        logic [31:0] ld;
        int st, sb;
        logic e;
        access(1'b0, 1'b1, 32'd0, 2'b00, 32'h10, 2'b10, 32'hDEADBEEF, ld, st, e, sb);
        ref_write(32'h10, 2'b10, 32'hDEADBEEF);
        n_cmp++; if (s_be[0] !== 4'b1111) begin n_fail++; $display("FAIL plan_st_be: got %b want 1111", s_be[0]); end
        n_cmp++; if (s_addr[0] !== AW'(4)) begin n_fail++; $display("FAIL plan_st_addr: got %h want 4", s_addr[0]); end
        n_cmp++; if (st !== 0) begin n_fail++; $display("FAIL plan_st_stall: got %0d want 0", st); end
        access(1'b1, 1'b0, 32'h13, 2'b00, 32'd0, 2'b00, 32'd0, ld, st, e, sb);
        n_cmp++; if (st !== 1) begin n_fail++; $display("FAIL plan_ld_stall: got %0d want 1", st); end
        n_cmp++; if (ld[7:0] !== 8'hDE) begin n_fail++; $display("FAIL plan_ld_byte: got %h want de", ld[7:0]); end
        access(1'b0, 1'b1, 32'd0, 2'b00, 32'h22, 2'b01, 32'h0000_1234, ld, st, e, sb);
        ref_write(32'h22, 2'b01, 32'h0000_1234);
        n_cmp++; if (s_be[0] !== 4'b1100) begin n_fail++; $display("FAIL plan_hw_be: got %b want 1100", s_be[0]); end
        n_cmp++; if (s_wdata[0][31:16] !== 16'h1234) begin n_fail++; $display("FAIL plan_hw_wdata: got %h want 1234", s_wdata[0][31:16]); end
        n_cmp++; if (st !== 0) begin n_fail++; $display("FAIL plan_hw_stall: got %0d want 0", st); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ld, a, d, exp_ld, msk;
        logic [1:0] w;
        int st, sb, kind, exp_st, exp_sb;
        logic e;
        bit mis, ok;
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 1);
            a = rand_addr();
            w = 2'($urandom_range(0, 2));
            d = $urandom;
            mis = spans(a, w);
            ok = !mis || SPLIT;
            exp_st = !ok ? 0 : (kind == 0) ? (mis ? 2 : 1) : (mis ? 1 : 0);
            exp_sb = !ok ? 0 : (mis ? 2 : 1);
            if (kind == 0) begin
                exp_ld = ok ? ref_read(a, w) : 32'd0;
                msk = ok ? wmask(w) : 32'hFFFF_FFFF;
                access(1'b1, 1'b0, a, w, 32'd0, 2'b00, 32'd0, ld, st, e, sb);
                n_cmp++; if ((ld & msk) !== exp_ld) begin n_fail++; $display("FAIL rand_ld_data: addr %h w %0d got %h want %h", a, w, ld & msk, exp_ld); end
            end else begin
                access(1'b0, 1'b1, 32'd0, 2'b00, a, w, d, ld, st, e, sb);
                if (ok) ref_write(a, w, d);
            end
            n_cmp++; if (st !== exp_st) begin n_fail++; $display("FAIL rand_stall: kind %0d addr %h w %0d got %0d want %0d", kind, a, w, st, exp_st); end
            n_cmp++; if (sb !== exp_sb) begin n_fail++; $display("FAIL rand_strobes: kind %0d addr %h got %0d want %0d", kind, a, sb, exp_sb); end
            n_cmp++; if (e !== (mis && !SPLIT)) begin n_fail++; $display("FAIL rand_err: addr %h w %0d got %b want %b", a, w, e, mis && !SPLIT); end
        end
    endtask

    task automatic test_load_store_together();
        logic [31:0] ld, la, sa, d, exp_ld;
        logic [1:0] lw, sw;
        int st, sb;
        logic e;
        for (int n = 0; n < 20; n++) begin
            la = rand_addr(); lw = 2'($urandom_range(0, 2));
            sa = rand_addr(); sw = 2'($urandom_range(0, 2));
            if (spans(la, lw)) la[1:0] = 2'b00;
            if (spans(sa, sw)) sa[1:0] = 2'b00;
            d = $urandom;
            exp_ld = ref_read(la, lw);
            access(1'b1, 1'b1, la, lw, sa, sw, d, ld, st, e, sb);
            ref_write(sa, sw, d);
            n_cmp++; if ((ld & wmask(lw)) !== exp_ld) begin n_fail++; $display("FAIL both_ld_data: got %h want %h", ld & wmask(lw), exp_ld); end
            n_cmp++; if (st !== 1) begin n_fail++; $display("FAIL both_stall: got %0d want 1", st); end
            n_cmp++; if (sb !== 2 || s_we[0] !== 1'b0 || s_we[1] !== 1'b1) begin n_fail++; $display("FAIL both_order: strobes %0d we0 %b we1 %b want 2 0 1", sb, s_we[0], s_we[1]); end
        end
    endtask

    task automatic test_hold();
        logic [31:0] ld, exp_ld;
        int st, sb;
        logic e;
        exp_ld = ref_read(32'h31, 2'b01);
        access(1'b1, 1'b0, 32'h31, 2'b01, 32'd0, 2'b00, 32'd0, ld, st, e, sb);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++; if ((ram_load_data & 32'hFFFF) !== exp_ld) begin n_fail++; $display("FAIL hold_data: cycle %0d got %h want %h", c, ram_load_data & 32'hFFFF, exp_ld); end
            @(posedge clk); #1;
        end
    endtask

`ifdef DATA_RAM_SPLIT_EN
    task automatic test_split_plan();
        logic [31:0] ld;
        int st, sb;
        logic e;
        access(1'b0, 1'b1, 32'd0, 2'b00, 32'h40, 2'b10, 32'h44332211, ld, st, e, sb);
        ref_write(32'h40, 2'b10, 32'h44332211);
        access(1'b0, 1'b1, 32'd0, 2'b00, 32'h44, 2'b10, 32'h88776655, ld, st, e, sb);
        ref_write(32'h44, 2'b10, 32'h88776655);
        access(1'b1, 1'b0, 32'h41, 2'b10, 32'd0, 2'b00, 32'd0, ld, st, e, sb);
        n_cmp++; if (st !== 2) begin n_fail++; $display("FAIL split_ld_stall: got %0d want 2", st); end
        n_cmp++; if (ld !== 32'h55443322) begin n_fail++; $display("FAIL split_ld_data: got %h want 55443322", ld); end
        access(1'b0, 1'b1, 32'd0, 2'b00, 32'h7E, 2'b10, 32'hAABBCCDD, ld, st, e, sb);
        ref_write(32'h7E, 2'b10, 32'hAABBCCDD);
        n_cmp++; if (st !== 1) begin n_fail++; $display("FAIL split_st_stall: got %0d want 1", st); end
        n_cmp++; if (s_be[0] !== 4'b1100 || s_addr[0] !== AW'('h1F)) begin n_fail++; $display("FAIL split_st_lo: be %b addr %h want 1100 01f", s_be[0], s_addr[0]); end
        n_cmp++; if (s_be[1] !== 4'b0011 || s_addr[1] !== AW'('h20)) begin n_fail++; $display("FAIL split_st_hi: be %b addr %h want 0011 020", s_be[1], s_addr[1]); end
        n_cmp++; if (s_wdata[0][31:16] !== 16'hCCDD || s_wdata[1][15:0] !== 16'hAABB) begin n_fail++; $display("FAIL split_st_wdata: lo %h hi %h want ccdd aabb", s_wdata[0][31:16], s_wdata[1][15:0]); end
        access(1'b1, 1'b0, 32'h7E, 2'b10, 32'd0, 2'b00, 32'd0, ld, st, e, sb);
        n_cmp++; if (ld !== 32'hAABBCCDD) begin n_fail++; $display("FAIL split_readback: got %h want aabbccdd", ld); end
    endtask

    task automatic test_reset_mid_split();
        int strobes;
        bit nonzero;
        ram_load_en = 1'b1; ram_load_addr = 32'h41; ram_load_width = 2'b10;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++; if (stall_req !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre_stall: got %b want 1", stall_req); end
        #1 rst = 1'b1;
        #1;
        n_cmp++; if (stall_req !== 1'b0 || sram_en !== 1'b0 || sram_be !== 4'b0) begin n_fail++; $display("FAIL rst_mid_outputs: stall %b en %b be %b want 0 0 0000", stall_req, sram_en, sram_be); end
        n_cmp++; if (ram_load_data !== 32'd0) begin n_fail++; $display("FAIL rst_mid_data: got %h want 0", ram_load_data); end
        @(posedge clk); #1;
        rst = 1'b0; ram_load_en = 1'b0;
        strobes = 0; nonzero = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (sram_en) strobes++;
            if (ram_load_data !== 32'd0) nonzero = 1'b1;
            @(posedge clk); #1;
        end
        n_cmp++; if (strobes !== 0) begin n_fail++; $display("FAIL rst_mid_strobes: got %0d want 0", strobes); end
        n_cmp++; if (nonzero !== 1'b0) begin n_fail++; $display("FAIL rst_mid_idle_data: got nonzero want 0"); end
    endtask
`else
    task automatic test_misaligned_off();
        logic [31:0] ld;
        int st, sb;
        logic e;
        access(1'b1, 1'b0, 32'h03, 2'b01, 32'd0, 2'b00, 32'd0, ld, st, e, sb);
        n_cmp++; if (e !== 1'b1) begin n_fail++; $display("FAIL mis_ld_err: got %b want 1", e); end
        n_cmp++; if (sb !== 0) begin n_fail++; $display("FAIL mis_ld_strobes: got %0d want 0", sb); end
        n_cmp++; if (st !== 0) begin n_fail++; $display("FAIL mis_ld_stall: got %0d want 0", st); end
        n_cmp++; if (ld !== 32'd0) begin n_fail++; $display("FAIL mis_ld_data: got %h want 0", ld); end
        @(negedge clk);
        n_cmp++; if (misaligned_err !== 1'b0) begin n_fail++; $display("FAIL mis_pulse_len: got %b want 0", misaligned_err); end
        @(posedge clk); #1;
        access(1'b0, 1'b1, 32'd0, 2'b00, 32'h05, 2'b10, 32'h12345678, ld, st, e, sb);
        n_cmp++; if (e !== 1'b1 || sb !== 0) begin n_fail++; $display("FAIL mis_st: err %b strobes %0d want 1 0", e, sb); end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b1;
        ram_load_en = 1'b0; ram_store_en = 1'b0;
        ram_load_addr = 32'd0; ram_store_addr = 32'd0; ram_store_data = 32'd0;
        ram_load_width = 2'b00; ram_store_width = 2'b00;
        test_reset();
        test_preload();
        test_plan_aligned();
        test_back_to_back();
        test_load_store_together();
        test_hold();
`ifdef DATA_RAM_SPLIT_EN
        test_split_plan();
        test_reset_mid_split();
`else
        test_misaligned_off();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
